// File: rtl/handshake_fifo.sv
// handshake_fifo: elastic req/ack buffer between a producer and a consumer.
// Upstream it acts as a consumer: it raises in_req and captures in_data on
// the one-cycle in_ack pulse. Downstream it acts as a producer: it answers a
// level out_req with a one-cycle out_ack pulse carrying out_data.
//
// Parameters: data_width (word width), depth (storage words, power of two
// >= 2), fifo_id (instance tag, only used in configuration messages).
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-low reset
//   in_req     registered request to the upstream source
//   in_ack     upstream data strobe, in_data valid in the same cycle
//   in_data    upstream word
//   out_req    level request from the downstream sink
//   out_ack    one-cycle pulse, out_data valid while high
//   out_data   downstream word, holds its value between pulses
//   count      current occupancy
//   overflow   sticky, set when a word arrives while full
// Optional build macro HANDSHAKE_FIFO_STATS_EN adds:
//   max_count     running maximum of count
//   stall_cycles  saturating count of cycles with out_req=1 while empty
module handshake_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4,
  parameter int unsigned fifo_id    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         in_req,
  input  logic                         in_ack,
  input  logic [data_width-1:0]        in_data,
  input  logic                         out_req,
  output logic                         out_ack,
  output logic [data_width-1:0]        out_data,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow
`ifdef HANDSHAKE_FIFO_STATS_EN
  ,
  output logic [$clog2(depth+1)-1:0]   max_count,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = $clog2(depth + 1);
  localparam logic [cw-1:0] full_count = cw'(depth);

  // Pointer wrap relies on depth being a power of two.
  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("handshake_fifo %0d: depth must be a power of two >= 2", fifo_id);
  end

  logic [data_width-1:0] mem [depth];
  logic [aw-1:0]         wp;
  logic [aw-1:0]         rp;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic [cw-1:0]         count_next;
  logic                  in_req_next;

  // Push/pop decisions use the registered count; out_ack gates back-to-back pops.
  always_comb begin
    push        = in_ack && (count != full_count);
    drop        = in_ack && (count == full_count);
    pop         = out_req && !out_ack && (count != '0);
    count_next  = count;
    if (push && !pop) begin
      count_next = count + cw'(1);
    end else if (pop && !push) begin
      count_next = count - cw'(1);
    end
    // Keep two free slots so the ack already in flight when in_req drops still fits.
    in_req_next = (depth - 32'(count_next)) >= 32'd2;
  end

  // Storage array; contents need no reset since pointers and count do.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wp] <= in_data;
    end
  end

  // Pointers, occupancy and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      in_req   <= 1'b0;
      out_ack  <= 1'b0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + aw'(1);
      end
      if (pop) begin
        rp       <= rp + aw'(1);
        out_data <= mem[rp];
      end
      out_ack <= pop;
      count   <= count_next;
      in_req  <= in_req_next;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef HANDSHAKE_FIFO_STATS_EN
  // Occupancy high-water mark and saturating empty-stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      max_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (count_next > max_count) begin
        max_count <= count_next;
      end
      if (out_req && (count == '0) && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/handshake_fifo.md
# handshake_fifo

Elastic buffer for the req/ack dataflow protocol used between producer, `arf` operators and consumer. It is inserted on any channel, typically between the bench producer and an `arf` input or between an `arf` output and the consumer. On its upstream side it behaves as a consumer: it drives `req` and captures data on `ack`. On its downstream side it behaves as a producer: it answers `req` with a one-cycle `ack` pulse plus data. It decouples upstream and downstream stalls, up to `depth` words.

## Interface
- `data_width`, 32, word width.
- `depth`, 4, storage words; power of two, ≥2.
- `fifo_id`, 0, instance tag; no functional effect.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset; sampled on posedge `clk`.
- `in_req`  out  1  request to upstream source.
- `in_ack`  in  1  one-cycle pulse from source; `in_data` valid in the same cycle.
- `in_data`  in  `data_width`  upstream word.
- `out_req`  in  1  level request from downstream sink.
- `out_ack`  out  1  one-cycle pulse; `out_data` valid while high.
- `out_data`  out  `data_width`  downstream word.
- `count`  out  `$clog2(depth+1)`  current occupancy.
- `overflow`  out  1  sticky; set when a word arrives while full.

## Operation
- Storage: circular RAM of `depth` words, with write pointer `wp` and read pointer `rp`, each `$clog2(depth)` bits.
  - Pointers wrap naturally (mod `depth`).
  - Full/empty are decided by `count`, not by pointer equality.
- Push: on a posedge with `in_ack`=1 and `count`<`depth`:
  - `mem[wp]`←`in_data`;
  - `wp`++.
- Overflow push: on a posedge with `in_ack`=1 and `count`=`depth`:
  - the word is dropped;
  - `overflow`←1 and stays 1 until reset;
  - `count`, `wp` and memory are unchanged.
- Pop: on a posedge with `out_req`=1, `out_ack`=0 and `count`>0:
  - `out_ack`←1;
  - `out_data`←`mem[rp]`;
  - `rp`++.
- Otherwise `out_ack`←0 and `out_data` holds its last value.
- Count rules:
  - push only: +1;
  - pop only: −1;
  - push and pop on the same edge: unchanged;
  - an overflow push counts as no push.
- `in_req` is registered. Its next value is 1 iff (`depth` − next `count`) ≥ 2, else 0.
  - The 2-slot threshold covers the one ack that may already be in flight after `in_req` falls, so a protocol-compliant source never causes overflow.
- No bypass: a word pushed on edge E is poppable no earlier than edge E+1.
- Downstream rate: at most one `out_ack` every 2 cycles, because `out_ack` gates the next pop.

## Timing
- Reset (rst=0 at a posedge):
  - `in_req`=0, `out_ack`=0, `out_data`=0, `count`=0, `overflow`=0, `wp`=`rp`=0;
  - stats counters = 0.
- Reset mid-operation discards all stored words. No `out_ack` is issued on the reset edge.
- First cycle after reset release: `in_req` rises on the first non-reset edge, because `depth`≥2.
- Latency: `in_ack` at edge E leads to `out_ack` high after edge E+1 at the earliest, given `out_req`=1 and the FIFO empty before E. That is 2 cycles in to out.
- Full boundary: `in_req` falls on the edge where the free slots become <2.
- Empty boundary: with `count`=0 and `out_req`=1, `out_ack` stays 0 indefinitely. No data changes.

## Configuration
- Macro `HANDSHAKE_FIFO_STATS_EN`.
- Defined: two extra output ports exist.
  - `max_count` (`$clog2(depth+1)` bits): running maximum of `count`.
  - `stall_cycles` (32 bits): increments every non-reset cycle with `out_req`=1 and `count`=0; saturates at 2^32−1.
- Undefined: both ports and their logic are absent. Core behaviour is identical in both builds.

## Test plan
- Reset then idle, with `out_req`=0 and an upstream producer delivering 0,1,2,…:
  - 4 words accepted (`depth`=4);
  - `in_req` falls when `count` reaches 3;
  - `count` settles at 4 (the in-flight word lands);
  - `overflow` stays 0.
- Then `out_req`=1 continuously:
  - `out_data` sequence is 0,1,2,3,4,…;
  - `out_ack` pulses every 2 cycles;
  - no word lost or duplicated over 5000 words.
- Forced `in_ack` pulse with `in_data`=0xDEAD while `count`=4:
  - `overflow`=1 and stays 1;
  - `count` stays 4;
  - 0xDEAD never appears on `out_data`.
- Simultaneous push and pop at `count`=2: `count` stays 2 and order is preserved.
- Assert `rst`=0 for one cycle with `count`=3:
  - next cycle `count`=0, `out_ack`=0, `out_data`=0;
  - subsequent output restarts from the first post-reset word.
- `HANDSHAKE_FIFO_STATS_EN` build, `out_req`=1 for 10 cycles on an empty FIFO, then a fill to 4:
  - `stall_cycles`=10;
  - `max_count`=4.
